// File: rtl/interp_pcm_n_if.sv
// Sample-stream bundle for the PCM interpolator: output-rate strobe, mode select,
// ready/valid input side and the registered output with its sticky status flags.
interface interp_pcm_n_if #(parameter int WIDTH = 24);
  logic                    enable;
  logic                    mode;
  logic signed [WIDTH-1:0] in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] out_data;
  logic                    out_valid;
  logic                    underrun;
  logic                    sat;

  modport master (
    output enable, mode, in_data, in_valid,
    input  in_ready, out_data, out_valid, underrun, sat
  );

  modport slave (
    input  enable, mode, in_data, in_valid,
    output in_ready, out_data, out_valid, underrun, sat
  );
endinterface

// File: rtl/interp_pcm_n.sv
// 2x/4x PCM interpolator built from one or two cascaded 7-tap halfband stages,
// clocked at modulator rate and advanced only on output-rate ticks.

// One halfband stage: phase 0 shifts a new sample in and passes the centre tap,
// phase 1 produces the interpolated midpoint (-d3 + 9*d2 + 9*d1 - d0) / 16.
module interp_pcm_n_hb #(parameter int WIDTH = 24) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_run,
  input  logic                    i_phase,
  input  logic signed [WIDTH-1:0] i_din,
  output logic signed [WIDTH-1:0] o_dout,
  output logic                    o_clip
);
  localparam int SW = WIDTH + 5;
  localparam logic signed [SW-1:0] RND  = SW'(8);
  localparam logic signed [SW-1:0] MAXV = {6'b000000, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {6'b111111, {(WIDTH-1){1'b0}}};

  logic [3:0][WIDTH-1:0]   r_d;
  logic signed [SW-1:0]    w_e0, w_e1, w_e2, w_e3, w_mid, w_sum, w_rnd;
  logic                    w_hi, w_lo;
  logic signed [WIDTH-1:0] w_y;

  always_comb begin
    w_e0  = {{5{r_d[0][WIDTH-1]}}, r_d[0]};
    w_e1  = {{5{r_d[1][WIDTH-1]}}, r_d[1]};
    w_e2  = {{5{r_d[2][WIDTH-1]}}, r_d[2]};
    w_e3  = {{5{r_d[3][WIDTH-1]}}, r_d[3]};
    w_mid = w_e1 + w_e2;
    w_sum = (w_mid <<< 3) + w_mid - w_e0 - w_e3;
    w_rnd = (w_sum + RND) >>> 4;
    w_hi  = (w_rnd > MAXV);
    w_lo  = (w_rnd < MINV);
    if (w_hi)      w_y = MAXV[WIDTH-1:0];
    else if (w_lo) w_y = MINV[WIDTH-1:0];
    else           w_y = w_rnd[WIDTH-1:0];
  end

  // Phase-0 output is d2 after the shift, i.e. d1 before it.
  assign o_dout = i_phase ? w_y : r_d[1];
  assign o_clip = i_run & i_phase & (w_hi | w_lo);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_d <= '0;
    else if (i_run && !i_phase) r_d <= {r_d[2:0], i_din};
  end
endmodule

module interp_pcm_n #(parameter int WIDTH = 24) (
  input  logic           clk,
  input  logic           rst,
  interp_pcm_n_if.slave  bus
);
  logic [1:0]              r_cnt;
  logic                    r_mode_q;
  logic signed [WIDTH-1:0] r_last, r_a_out, r_out;
  logic                    r_vld, r_und, r_sat;

  logic                    w_tick, w_first, w_mode, w_take;
  logic signed [WIDTH-1:0] w_samp, w_a_y, w_b_y, w_y;
  logic                    w_a_run, w_a_ph, w_a_clip;
  logic                    w_b_run, w_b_ph, w_b_clip;
  logic [1:0]              w_cnt_nxt;

  // The frame's mode is taken live on its first tick so that tick already obeys it.
  assign w_tick  = bus.enable;
  assign w_first = (r_cnt == 2'd0);
  assign w_mode  = w_first ? bus.mode : r_mode_q;
  assign w_take  = w_tick & w_first;
  assign w_samp  = bus.in_valid ? bus.in_data : r_last;

  assign w_a_run = w_tick & (~w_mode | ~r_cnt[0]);
  assign w_a_ph  = w_mode ? r_cnt[1] : r_cnt[0];
  assign w_b_run = w_tick & w_mode;
  assign w_b_ph  = r_cnt[0];

  interp_pcm_n_hb #(.WIDTH(WIDTH)) u_hb_a (
    .clk     (clk),
    .rst     (rst),
    .i_run   (w_a_run),
    .i_phase (w_a_ph),
    .i_din   (w_samp),
    .o_dout  (w_a_y),
    .o_clip  (w_a_clip)
  );

  // Stage B consumes the previous A step's result, giving a one-A-step pipeline.
  interp_pcm_n_hb #(.WIDTH(WIDTH)) u_hb_b (
    .clk     (clk),
    .rst     (rst),
    .i_run   (w_b_run),
    .i_phase (w_b_ph),
    .i_din   (r_a_out),
    .o_dout  (w_b_y),
    .o_clip  (w_b_clip)
  );

  assign w_y       = w_mode ? w_b_y : w_a_y;
  assign w_cnt_nxt = w_mode ? r_cnt + 2'd1 : {1'b0, ~r_cnt[0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_mode_q <= 1'b0;
      r_last   <= '0;
      r_a_out  <= '0;
      r_out    <= '0;
      r_vld    <= 1'b0;
      r_und    <= 1'b0;
      r_sat    <= 1'b0;
    end else begin
      r_vld <= w_tick;
      if (w_tick) begin
        r_cnt <= w_cnt_nxt;
        r_out <= w_y;
        r_sat <= r_sat | w_a_clip | w_b_clip;
        if (w_first) r_mode_q <= bus.mode;
        if (w_mode && !r_cnt[0]) r_a_out <= w_a_y;
        if (w_take) begin
          if (bus.in_valid) r_last <= bus.in_data;
          else              r_und  <= 1'b1;
        end
      end
    end
  end

  assign bus.in_ready  = w_first;
  assign bus.out_data  = r_out;
  assign bus.out_valid = r_vld;
  assign bus.underrun  = r_und;
  assign bus.sat       = r_sat;
endmodule

// File: tb/tb_interp_pcm_n.sv
// Directed bench for interp_pcm_n: an arithmetic tick model checked every cycle,
// plus hand-computed literal expectations per scenario.
module tb_interp_pcm_n;
  localparam int W = 24;
  localparam longint MAXP = (longint'(1) <<< (W-1)) - 1;
  localparam longint MINN = -(longint'(1) <<< (W-1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  interp_pcm_n_if #(.WIDTH(W)) bus ();
  interp_pcm_n #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 0;

  // Model state: two 4-deep histories (index 0 newest), frame counter, pipeline reg.
  longint q[2][4];
  longint m_aout, m_last;
  int     mcnt;
  bit     mmq;
  longint e_out;
  bit     e_vld, e_rdy, e_und, e_sat;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) for (int i = 0; i < 4; i++) q[s][i] = 0;
    m_aout = 0; m_last = 0; mcnt = 0; mmq = 0;
    e_out = 0; e_vld = 0; e_rdy = 1; e_und = 0; e_sat = 0;
  endtask

  task automatic stage(input int s, input int ph, input longint x, output longint y);
    longint acc;
    if (ph == 0) begin
      for (int i = 3; i > 0; i--) q[s][i] = q[s][i-1];
      q[s][0] = x;
      y = q[s][2];
    end else begin
      acc = 9 * (q[s][1] + q[s][2]) - q[s][0] - q[s][3];
      acc = (acc + 8) >>> 4;
      if (acc > MAXP) begin acc = MAXP; e_sat = 1; end
      if (acc < MINN) begin acc = MINN; e_sat = 1; end
      y = acc;
    end
  endtask

  task automatic model_tick(input bit m, input bit v, input longint d);
    bit em;
    longint samp, aprev, ya;
    em   = (mcnt == 0) ? m : mmq;
    samp = m_last;
    if (mcnt == 0) begin
      mmq = m;
      if (v) begin samp = d; m_last = d; end
      else e_und = 1;
    end
    aprev = m_aout;
    if (!em) stage(0, mcnt % 2, samp, e_out);
    else begin
      if (mcnt % 2 == 0) begin stage(0, mcnt / 2, samp, ya); m_aout = ya; end
      stage(1, mcnt % 2, aprev, e_out);
    end
    mcnt = em ? (mcnt + 1) % 4 : (mcnt + 1) % 2;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("out_valid", longint'(bus.out_valid), longint'(e_vld));
      chk("out_data",  longint'(bus.out_data),  e_out);
      chk("in_ready",  longint'(bus.in_ready),  longint'(e_rdy));
      chk("underrun",  longint'(bus.underrun),  longint'(e_und));
      chk("sat",       longint'(bus.sat),       longint'(e_sat));
    end
  end

  // One clock: drive at negedge+1, sample the DUT at posedge+1.
  task automatic step(input bit en, input bit m, input bit v, input longint d, output longint y);
    @(negedge clk); #1;
    bus.enable = en; bus.mode = m; bus.in_valid = v; bus.in_data = d[W-1:0];
    @(posedge clk); #1;
    if (en) model_tick(m, v, d);
    e_vld = en;
    e_rdy = (mcnt == 0);
    y = longint'(bus.out_data);
  endtask

  task automatic do_reset(input bit check);
    @(posedge clk); #3;
    rst = 1'b1; bus.enable = 1'b0; bus.in_valid = 1'b0;
    #1;
    if (check) begin
      chk("rst_out_data",  longint'(bus.out_data),  0);
      chk("rst_out_valid", longint'(bus.out_valid), 0);
      chk("rst_in_ready",  longint'(bus.in_ready),  1);
      chk("rst_underrun",  longint'(bus.underrun),  0);
      chk("rst_sat",       longint'(bus.sat),       0);
    end
    model_reset();
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint y, v;
    int hi, lo;
    longint imp[9];
    imp = '{0, -1, 0, 9, 16, 9, 0, -1, 0};
    bus.enable = 0; bus.mode = 0; bus.in_valid = 0; bus.in_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset(1);
    chk_on = 1;

    // 2x impulse
    for (int k = 0; k < 9; k++) begin
      step(1, 0, 1, (k == 0) ? 16 : 0, y);
      chk("imp_out", y, imp[k]);
    end
    chk("imp_sat", longint'(bus.sat), 0);
    chk("imp_und", longint'(bus.underrun), 0);

    // 2x DC
    do_reset(0);
    for (int k = 0; k < 20; k++) begin
      step(1, 0, 1, 1000, y);
      if (k >= 7) chk("dc2_out", y, 1000);
    end

    // 4x DC with enable every third cycle
    do_reset(0);
    for (int k = 0; k < 40; k++) begin
      step(1, 1, 1, -5000, y);
      if (k >= 20) chk("dc4_out", y, -5000);
      chk("dc4_ready", longint'(bus.in_ready), longint'((k + 1) % 4 == 0));
      step(0, 1, 1, 1234, y);
      chk("dc4_idle_vld", longint'(bus.out_valid), 0);
      step(0, 0, 0, 0, y);
    end

    // Saturation: rails in pairs so the 9/9 taps line up against the -1 taps
    do_reset(0);
    hi = 0; lo = 0;
    for (int k = 0; k < 24; k++) begin
      v = (((k / 2) / 2) % 2 == 0) ? MAXP : MINN;
      step(1, 0, 1, v, y);
      if (y == MAXP) hi++;
      if (y == MINN) lo++;
    end
    chk("sat_flag", longint'(bus.sat), 1);
    chk("sat_hit_hi", longint'(hi > 0), 1);
    chk("sat_hit_lo", longint'(lo > 0), 1);
    for (int k = 0; k < 8; k++) step(1, 0, 1, 7, y);
    chk("sat_sticky", longint'(bus.sat), 1);

    // Underrun: one good frame, two starved frames, then good again
    do_reset(0);
    for (int k = 0; k < 14; k++) begin
      step(1, 0, !(k >= 2 && k < 6), (k >= 2 && k < 6) ? 777 : 300, y);
      if (k == 1) chk("und_early", longint'(bus.underrun), 0);
      if (k == 2) chk("und_set", longint'(bus.underrun), 1);
      if (k >= 7) chk("und_out", y, 300);
    end
    chk("und_sticky", longint'(bus.underrun), 1);

    // Mode switch mid-frame, then asynchronous reset mid-frame
    do_reset(0);
    step(1, 0, 1, 100, y);
    step(1, 1, 1, 100, y);
    chk("msw_hold_rdy", longint'(bus.in_ready), 1);
    step(1, 1, 1, 100, y);
    chk("msw_4x_rdy1", longint'(bus.in_ready), 0);
    step(1, 0, 1, 100, y);
    step(1, 0, 1, 100, y);
    chk("msw_4x_rdy3", longint'(bus.in_ready), 0);
    step(1, 0, 1, 100, y);
    chk("msw_4x_wrap", longint'(bus.in_ready), 1);
    for (int k = 0; k < 14; k++) step(1, 1, 1, 100, y);
    chk("msw_busy", longint'(bus.in_ready), 0);
    chk("msw_nonzero", longint'(bus.out_data != 0), 1);
    do_reset(1);
    for (int k = 0; k < 6; k++) step(1, 0, 1, -42, y);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/interp_pcm_n.md
# interp_pcm_n

Parametrised PCM interpolator: upsamples a signed PCM stream by 2x or 4x (run-time selectable) using one or two cascaded 7-tap halfband stages. Sits between the sample source and the delta-sigma modulator and runs at modulator clock with an output-rate `enable` strobe. Unlike the fixed 2x stage it replaces, it has a ready/valid input handshake, an underrun policy, saturation and sticky status flags.

## Interface
- `WIDTH`, 24, sample width (signed two's complement), in and out

- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `enable`  in  1  output-rate tick; one output sample per cycle with `enable`=1
- `mode`  in  1  0 = 2x, 1 = 4x; latched at frame start
- `in_data`  in  WIDTH  input sample
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  block takes a sample on this cycle if `enable`=1
- `out_data`  out  WIDTH  interpolated sample
- `out_valid`  out  1  one-cycle pulse, registered with `out_data`
- `underrun`  out  1  sticky: input missing when required
- `sat`  out  1  sticky: an output was clipped

## Operation
- Tick = cycle with `enable`=1. No state changes on non-tick cycles.
- Tick counter `cnt`: wraps 0..1 in 2x, 0..3 in 4x. Frame = ticks from `cnt`=0 to wrap.
- `mode_q` loads `mode` on every tick with `cnt`=0 and holds for the whole frame, including that tick. Mid-frame `mode` changes are ignored. Delay lines are not flushed on a mode change.
- `in_ready` = (`cnt`==0), combinational from `cnt`, independent of `mode`.
- Each halfband stage has a 4-entry delay line d0 (newest) .. d3 (oldest) and two phases:
  - Phase 0: shift the stage input into d0. Output = d2 after the shift.
  - Phase 1: no shift. Output = (-d3 + 9*d2 + 9*d1 - d0) / 16.
- Arithmetic for phase 1:
  - Sum in WIDTH+5 signed bits.
  - Add 8, arithmetic shift right by 4.
  - Saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. Any clip sets `sat`.
- 2x mode:
  - Stage A runs every tick with phase = `cnt[0]`.
  - Stage A's phase-0 input is the handshake sample.
  - `out_data` = stage A output.
- 4x mode:
  - Stage A runs on ticks with `cnt[0]`=0, phase = `cnt[1]`. Its result goes to register `a_out`.
  - Stage B runs every tick, phase = `cnt[0]`.
  - Stage B's phase-0 input is the value of `a_out` before that tick's update (one A-step pipeline).
  - `out_data` = stage B output.
- Handshake, on a tick with `cnt`=0:
  - `in_valid`=1: sample accepted.
  - `in_valid`=0: the last accepted sample is shifted in instead (zero after reset), and `underrun` is set.
  - `in_valid` on non-ready cycles is ignored.
- `underrun` and `sat` clear only on reset.

## Timing
- Reset (asynchronous, any time, including mid-frame) clears all of the following:
  - `cnt` = 0, `mode_q` = 0
  - both delay lines, `a_out`, the held last sample
  - `out_data` = 0, `out_valid` = 0, `underrun` = 0, `sat` = 0
- Reset forces `in_ready` = 1.
- After reset release the first tick is `cnt`=0.
- `out_data`/`out_valid` update on the clock edge of the tick. `out_valid` is high for exactly one cycle after each tick.
- Consecutive ticks (`enable` held high) give one output per clock.
- 2x latency: an input accepted on tick k appears as a phase-0 output on tick k+4, its own value unaltered.
- 4x DC settling: with constant input from the first tick after reset, all outputs equal the input from tick 20 onward.

## Test plan
- 2x impulse: `mode`=0, `enable`=1 continuously, inputs 16, 0, 0, 0, ... -> `out_data` on ticks 0..8 = 0, -1, 0, 9, 16, 9, 0, -1, 0; `sat`=0; `underrun`=0.
- 2x DC: input 1000 every frame -> from tick 7 onward every output = 1000.
- 4x DC plus sparse enable: `mode`=1, `enable` every 3rd cycle, input -5000 -> from tick 20 all outputs -5000; exactly one `out_valid` per tick; `in_ready` high only on `cnt`=0 ticks.
- Saturation: WIDTH=24, `mode`=0, inputs alternate +8388607 and -8388608 -> outputs clip to rails and `sat` = 1 and stays 1.
- Underrun: `mode`=0, input 300, then deassert `in_valid` for two frames -> the held 300 keeps being used, outputs settle to 300, `underrun` = 1 and sticky.
- Mode switch plus reset: set `mode` 0->1 at `cnt`=1 -> the change takes effect at the next `cnt`=0 tick. Assert `rst` mid-frame -> all outputs and flags 0 immediately, and `in_ready`=1.
